// File: rtl/add_round_key_engine.sv
// Registered, handshaked AddRoundKey stage with an internal round-key bank.
// Serves forward and inverse datapaths; one word per cycle, 1-cycle latency.
module add_round_key_engine #(
  parameter  int unsigned DATA_W   = 128,
  parameter  int unsigned NUM_KEYS = 11,
  localparam int unsigned IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_wr_en,
  input  logic [IDX_W-1:0]    key_wr_idx,
  input  logic [DATA_W-1:0]   key_wr_data,
  input  logic                key_clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_state,
  input  logic [IDX_W-1:0]    in_round,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_state,
  output logic                out_err,
  output logic [NUM_KEYS-1:0] key_loaded
);

  localparam int unsigned      NBYTES   = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("add_round_key_engine: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0]   bank [NUM_KEYS];
  logic                accept_c;
  logic                round_ok_c;
  logic                wr_ok_c;
  logic                wr_hit_c;
  logic                stored_loaded_c;
  logic                sel_loaded_c;
  logic [IDX_W-1:0]    phys_c;
  logic [DATA_W-1:0]   sel_key_c;
  logic [DATA_W-1:0]   keyed_c;
  logic                err_c;
  logic [NUM_KEYS-1:0] loaded_nxt_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Logical round to physical bank entry; inverse cipher walks the bank backwards.
  assign round_ok_c = 32'(in_round) < NUM_KEYS;
  assign wr_ok_c    = 32'(key_wr_idx) < NUM_KEYS;
  assign phys_c     = in_inv ? (LAST_IDX - in_round) : in_round;

  // Key lookup with write-first bypass; a same-cycle clear hides stale entries.
  always_comb begin
    sel_key_c       = '0;
    stored_loaded_c = 1'b0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (phys_c == IDX_W'(k)) begin
        sel_key_c       = bank[k];
        stored_loaded_c = key_loaded[k];
      end
    end
    wr_hit_c = key_wr_en && wr_ok_c && (key_wr_idx == phys_c);
    if (wr_hit_c) begin
      sel_key_c = key_wr_data;
    end
    sel_loaded_c = wr_hit_c || (stored_loaded_c && !key_clear);
  end

  // Bytewise XOR; out-of-range rounds pass the state through untouched.
  always_comb begin
    keyed_c = in_state;
    err_c   = 1'b1;
    if (round_ok_c) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        keyed_c[8*b +: 8] = in_state[8*b +: 8] ^ sel_key_c[8*b +: 8];
      end
      err_c = !sel_loaded_c;
    end
  end

  // Valid-bit update: clear wins everywhere except the entry being written.
  always_comb begin
    loaded_nxt_c = key_clear ? '0 : key_loaded;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (key_wr_en && (key_wr_idx == IDX_W'(k))) begin
        loaded_nxt_c[k] = 1'b1;
      end
    end
  end

  // Bank storage carries no reset; validity is tracked by key_loaded.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (key_wr_en && (key_wr_idx == IDX_W'(k))) begin
        bank[k] <= key_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_loaded <= '0;
    end else begin
      key_loaded <= loaded_nxt_c;
    end
  end

  // Output register: load on accept, hold while stalled, drop once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_err   <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_state <= keyed_c;
      out_err   <= err_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_engine.sv
// Directed self-checking bench for add_round_key_engine (DATA_W=128, NUM_KEYS=11).
module tb_add_round_key_engine;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned NUM_KEYS = 11;
  localparam int unsigned IDX_W    = 4;

  logic                clk;
  logic                rst_n;
  logic                key_wr_en;
  logic [IDX_W-1:0]    key_wr_idx;
  logic [DATA_W-1:0]   key_wr_data;
  logic                key_clear;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_state;
  logic [IDX_W-1:0]    in_round;
  logic                in_inv;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_state;
  logic                out_err;
  logic [NUM_KEYS-1:0] key_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  add_round_key_engine #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_clear(key_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_round(in_round), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_err(out_err), .key_loaded(key_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] bcast(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {16{b}};
  endfunction

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'h9E37_79B9 * 32'(i + 1);
    return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] q[$];
    logic [127:0] prev;
    logic         stall_prev;
    int           sent;
    int           got;

    rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    key_clear = 1'b0; in_valid = 1'b0; in_state = '0; in_round = '0;
    in_inv = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_out_err", 128'(out_err), 128'(0));
    chk("rst_key_loaded", 128'(key_loaded), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load keys 0..10 with key k = {16{k}}
    for (int k = 0; k < 11; k++) begin
      key_wr_en = 1'b1; key_wr_idx = IDX_W'(k); key_wr_data = bcast(k);
      tick();
    end
    key_wr_en = 1'b0;
    chk("load_all", 128'(key_loaded), 128'(11'h7FF));

    // Forward round 3 on zero state, 1-cycle latency
    in_valid = 1'b1; in_state = '0; in_round = 4'd3; in_inv = 1'b0;
    @(negedge clk);
    chk("lat_pre_valid", 128'(out_valid), 128'(0));
    tick();
    in_valid = 1'b0;
    chk("fwd3_valid", 128'(out_valid), 128'(1));
    chk("fwd3_state", out_state, {16{8'h03}});
    chk("fwd3_err", 128'(out_err), 128'(0));
    tick();
    chk("fwd3_drain", 128'(out_valid), 128'(0));

    // Inverse round 1 -> key 9 on all-ones state
    in_valid = 1'b1; in_state = '1; in_round = 4'd1; in_inv = 1'b1;
    tick();
    in_valid = 1'b0; in_inv = 1'b0;
    chk("inv1_state", out_state, {16{8'hF6}});
    chk("inv1_err", 128'(out_err), 128'(0));
    tick();

    // Stream 20 words with out_ready pattern 1,0,0,1
    sent = 0; got = 0; stall_prev = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      in_valid  = (sent < 20);
      in_state  = pat(sent);
      in_round  = IDX_W'(sent % 11);
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clk);
      chk("strm_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
      chk("strm_valid", 128'(out_valid), 128'(q.size() != 0));
      if (stall_prev) chk("strm_hold", out_state, prev);
      if (out_valid && out_ready && q.size() != 0) begin
        chk("strm_data", out_state, q.pop_front());
        chk("strm_err", 128'(out_err), 128'(0));
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(pat(sent) ^ bcast(sent % 11));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      prev = out_state;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("strm_count", 128'(got), 128'(20));
    tick();

    // Fresh reset: no keys loaded
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("rst2_key_loaded", 128'(key_loaded), 128'(0));
    in_valid = 1'b1; in_state = pat(7); in_round = 4'd2;
    tick();
    chk("unloaded_err", 128'(out_err), 128'(1));
    chk("unloaded_valid", 128'(out_valid), 128'(1));
    in_round = 4'd11;
    tick();
    chk("oob_state", out_state, pat(7));
    chk("oob_err", 128'(out_err), 128'(1));
    in_round = 4'd15; in_inv = 1'b1; in_state = pat(8);
    tick();
    in_valid = 1'b0; in_inv = 1'b0;
    chk("oob_inv_state", out_state, pat(8));
    chk("oob_inv_err", 128'(out_err), 128'(1));
    tick();

    // Write-first: write idx 5 while reading round 5
    key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = {16{8'hA5}};
    in_valid = 1'b1; in_state = '0; in_round = 4'd5;
    tick();
    key_wr_en = 1'b0; in_valid = 1'b0;
    chk("wf_state", out_state, {16{8'hA5}});
    chk("wf_err", 128'(out_err), 128'(0));
    chk("wf_loaded", 128'(key_loaded), 128'(11'h020));
    tick();

    // Out-of-range write is ignored
    key_wr_en = 1'b1; key_wr_idx = 4'd12; key_wr_data = '1;
    tick();
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = {16{8'h3C}};
    tick();
    key_wr_en = 1'b0;
    chk("oob_write_loaded", 128'(key_loaded), 128'(11'h024));

    // Clear + write idx 5 with same-cycle read of cleared idx 2; output then stalls
    out_ready = 1'b0;
    key_clear = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = {16{8'h11}};
    in_valid = 1'b1; in_state = {16{8'hFF}}; in_round = 4'd2;
    tick();
    key_clear = 1'b0; key_wr_en = 1'b0; in_valid = 1'b0;
    chk("clr_loaded", 128'(key_loaded), 128'(11'h020));
    chk("clr_read_err", 128'(out_err), 128'(1));
    prev = out_state;
    // Key traffic must not disturb a held output word
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = {16{8'h77}};
    tick();
    key_wr_en = 1'b0;
    chk("hold_vs_wr_state", out_state, prev);
    chk("hold_vs_wr_valid", 128'(out_valid), 128'(1));
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("stall_release", 128'(out_valid), 128'(0));

    // Async reset with a stalled erroneous word in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = pat(3); in_round = 4'd11;
    tick();
    in_valid = 1'b0;
    chk("pre_arst_valid", 128'(out_valid), 128'(1));
    chk("pre_arst_err", 128'(out_err), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_err", 128'(out_err), 128'(0));
    chk("arst_loaded", 128'(key_loaded), 128'(0));
    #10;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_round_key_engine.md
Name: add_round_key_engine

Overview:
Registered, handshaked AddRoundKey stage serving both the forward and the inverse cipher datapaths. It holds an internal bank of round keys loaded by the key-expansion logic. Each accepted state word is XORed with the key selected by round index and direction. It replaces the ad-hoc combinational XOR between round stages, so round pipelines can stall and reuse one key bank.

Parameters:
DATA_W, 128, state/key width in bits; must be a multiple of 8.
NUM_KEYS, 11, round keys stored (11/13/15 for AES-128/192/256).
IDX_W, $clog2(NUM_KEYS), round-index width (derived, not overridden).

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
key_wr_en  in  1  write key_wr_data into bank entry key_wr_idx.
key_wr_idx  in  IDX_W  key bank write address.
key_wr_data  in  DATA_W  round key to store.
key_clear  in  1  invalidate all bank entries (data kept, valid bits cleared).
in_valid  in  1  input state valid.
in_ready  out  1  block can accept input this cycle.
in_state  in  DATA_W  state to be keyed.
in_round  in  IDX_W  logical round number.
in_inv  in  1  1 = inverse cipher: physical index = NUM_KEYS-1-in_round.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts output.
out_state  out  DATA_W  in_state XOR selected key.
out_err  out  1  word was processed with a bad or unloaded key index.
key_loaded  out  NUM_KEYS  per-entry valid bitmap.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): out_valid=0, out_state=0, out_err=0, key_loaded=0. Bank contents are don't-care after reset.
- Handshake: input transfers on in_valid&&in_ready; output transfers on out_valid&&out_ready. in_ready = !out_valid || out_ready, combinational, so full throughput is one word per cycle with no bubbles.
- Latency: exactly 1 cycle. A word accepted at edge N appears on out_* after edge N.
- Output register holds out_state/out_err stable while out_valid&&!out_ready. When a word is accepted, the register is overwritten with the new word. Otherwise, if the output is taken, out_valid drops to 0.
- Index: phys = in_inv ? NUM_KEYS-1-in_round : in_round.
  - in_round >= NUM_KEYS: out_state = in_state unmodified, out_err=1.
  - key_loaded[phys]==0: out_state = in_state XOR stored bits, out_err=1.
  - Otherwise out_err=0.
- XOR is bytewise across all DATA_W/8 bytes with no carries: byte i of output = byte i of state ^ byte i of key.
- Key write: bank[key_wr_idx] <= key_wr_data and key_loaded[key_wr_idx] <= 1. A write with key_wr_idx >= NUM_KEYS is ignored.
- Write/read same cycle, same index: write-first. The accepted word uses key_wr_data, out_err=0 for that word, and key_loaded is treated as set.
- key_clear and key_wr_en in the same cycle: clear wins for all entries except key_wr_idx, which ends loaded with the new data. A same-cycle read of a cleared entry sees it unloaded (out_err=1).
- Key writes and clears never stall the data path and never alter a word already in the output register.
- Reset mid-stream: an in-flight output word is dropped (out_valid=0 immediately), and the bank must be reloaded.

Test Plan:
- Load keys 0..10 with key k = {16{8'(k)}}, then send state 128'h0 round 3 fwd → out_state = {16{8'h03}}, out_err=0, 1-cycle latency.
- Same load, state all-ones, round 1, in_inv=1 → key index 9, out_state = {16{8'hF6}}.
- Stream 20 back-to-back words with out_ready toggling 1,0,0,1,… → no drop or duplicate, order kept, out_state stable during stall, in_ready low only when out_valid&&!out_ready.
- Fresh reset, no keys, send round 2 → out_err=1. Then send round 11 with NUM_KEYS=11 → out_state = in_state, out_err=1.
- key_wr_en to index 5 with 128'hA5…A5 in the same cycle as input state 0 round 5 → out_state = A5…A5, out_err=0. key_clear+write idx 5 same cycle → key_loaded = 11'h020.
- Assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid, out_err and key_loaded go 0 without waiting for a clock edge.
